// File: rtl/pwm_3phase_center_if.sv
// Sample handshake and gate-drive bundle between the inverse Clarke stage,
// the center-aligned PWM block and the inverter gate drivers.
interface pwm_3phase_center_if #(
   parameter int D_WIDTH = 32
) ();
   logic                      in_valid;
   logic                      in_ready;
   logic signed [D_WIDTH-1:0] a;
   logic signed [D_WIDTH-1:0] b;
   logic signed [D_WIDTH-1:0] c;
   logic [2:0]                pwm_h;
   logic [2:0]                pwm_l;
   logic                      period_start;

   modport master (
      output in_valid, a, b, c,
      input  in_ready, pwm_h, pwm_l, period_start
   );

   modport slave (
      input  in_valid, a, b, c,
      output in_ready, pwm_h, pwm_l, period_start
   );
endinterface

// File: rtl/pwm_3phase_center.sv
// Center-aligned 3-phase PWM: triangle carrier, valley-synchronised double-buffered
// duties and per-leg dead-time insertion on complementary gate outputs.
module pwm_3phase_center #(
   parameter int D_WIDTH   = 32,
   parameter int Q_BITS    = 10,
   parameter int CNT_WIDTH = 16,
   parameter int PERIOD    = 1000,
   parameter int DEADTIME  = 10
) (
   input logic                 clk,
   input logic                 rst,
   pwm_3phase_center_if.slave  bus
);
   localparam int PW   = 2 * D_WIDTH;
   localparam int DT_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);

   localparam logic [CNT_WIDTH-1:0] PERIOD_C = CNT_WIDTH'(PERIOD);
   localparam logic [CNT_WIDTH-1:0] HALF_C   = CNT_WIDTH'(PERIOD / 2);
   localparam logic signed [PW-1:0] PERIOD_W = PW'(PERIOD);
   localparam logic signed [PW-1:0] HALF_W   = PW'(PERIOD / 2);
   localparam logic [DT_W-1:0]      DT_C     = DT_W'(DEADTIME);

   typedef enum logic {EMPTY, FULL} buf_state_t;

   // Phase voltage to compare value: half period offset plus scaled voltage, floored, clamped.
   function automatic logic [CNT_WIDTH-1:0] map_duty(input logic signed [D_WIDTH-1:0] v);
      logic signed [PW-1:0] prod;
      logic signed [PW-1:0] val;
      prod = PW'(v) * PERIOD_W;
      val  = (prod >>> (Q_BITS + 1)) + HALF_W;
      if (val[PW-1]) begin
         map_duty = '0;
      end else if (val > PERIOD_W) begin
         map_duty = PERIOD_C;
      end else begin
         map_duty = val[CNT_WIDTH-1:0];
      end
   endfunction

   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 up_reg;
   logic                 up_next;
   logic                 valley;

   buf_state_t state_reg;
   buf_state_t state_next;
   logic       ready;
   logic       load_pend;
   logic       transfer;

   logic signed [D_WIDTH-1:0] phase_in [3];

   assign phase_in[0] = bus.a;
   assign phase_in[1] = bus.b;
   assign phase_in[2] = bus.c;

   assign valley           = (cnt_reg == '0);
   assign bus.period_start = valley & ~rst;
   assign bus.in_ready     = ready;

   always_comb begin
      cnt_next = cnt_reg;
      up_next  = up_reg;
      if (up_reg) begin
         if (cnt_reg == PERIOD_C) begin
            cnt_next = cnt_reg - 1'b1;
            up_next  = 1'b0;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end else begin
         if (cnt_reg == '0) begin
            cnt_next = cnt_reg + 1'b1;
            up_next  = 1'b1;
         end else begin
            cnt_next = cnt_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
         up_reg  <= 1'b1;
      end else begin
         cnt_reg <= cnt_next;
         up_reg  <= up_next;
      end
   end

   // Shadow buffer: one pending sample, released into the active compares at the valley.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY:   if (bus.in_valid) state_next = FULL;
         FULL:    if (valley)       state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      ready     = (state_reg == EMPTY) & ~rst;
      load_pend = ready & bus.in_valid;
      transfer  = (state_reg == FULL) & valley;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_phase
      logic [CNT_WIDTH-1:0] pend_reg;
      logic [CNT_WIDTH-1:0] act_reg;
      logic                 raw;
      logic                 raw_q_reg;
      logic [DT_W-1:0]      dt_reg;
      logic [DT_W-1:0]      dt_next;
      logic                 h_reg;
      logic                 l_reg;

      assign raw = (act_reg == PERIOD_C) | (cnt_reg < act_reg);

      always_ff @(posedge clk) begin
         if (rst) begin
            pend_reg <= '0;
            act_reg  <= HALF_C;
         end else begin
            if (load_pend) pend_reg <= map_duty(phase_in[gi]);
            if (transfer)  act_reg  <= pend_reg;
         end
      end

      // Any change of the registered raw level restarts the blanking interval.
      always_comb begin
         dt_next = dt_reg;
         if (raw != raw_q_reg) begin
            dt_next = DT_C;
         end else if (dt_reg != '0) begin
            dt_next = dt_reg - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            raw_q_reg <= 1'b0;
            dt_reg    <= DT_C;
            h_reg     <= 1'b0;
            l_reg     <= 1'b0;
         end else begin
            raw_q_reg <= raw;
            dt_reg    <= dt_next;
            h_reg     <= (dt_next == '0) & raw;
            l_reg     <= (dt_next == '0) & ~raw;
         end
      end

      assign bus.pwm_h[gi] = h_reg;
      assign bus.pwm_l[gi] = l_reg;
   end
endmodule
